bank_isu_linefill_tracker: RTL and testbench



---
 rtl/bank_isu_linefill_tracker.sv | 153 +++++++++++++++
 tb/tb_bank_isu_linefill_tracker.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/bank_isu_linefill_tracker.sv
// -----------------------------------------------------------------------------
// bank_isu_linefill_tracker
//
// Tracks every outstanding linefill per cache line {set, way}. Each entry
// moves IDLE -> PEND (allocated) -> FILLED (BIU data returned) -> IDLE (last
// dependent released by the issue queue). It also counts the dependent
// requests merged onto each line and caps the number of lines in flight.
//
// Ports
//   clk_i, rst_i       clock, synchronous active-high reset
//   alloc_*            HTU allocation request / ready handshake
//   query_*            HTU lookup address; inflight and waiter-full status
//   merge_valid_i      add one waiter to the queried entry
//   fill_valid_i/id    BIU read return, id = {set, way}
//   release_valid_i/id issue queue consumed one dependent of {set, way}
//   inflight_cnt_o     number of non-IDLE entries
//   err_o              registered one-cycle protocol-violation pulse
// -----------------------------------------------------------------------------
module bank_isu_linefill_tracker #(
    parameter int SET_W        = 3,
    parameter int WAY_W        = 3,
    parameter int CNT_W        = 3,
    parameter int MAX_INFLIGHT = 16,
    parameter int ICW          = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   alloc_valid_i,
    input  logic [SET_W-1:0]       alloc_set_i,
    input  logic [WAY_W-1:0]       alloc_way_i,
    output logic                   alloc_ready_o,
    input  logic [SET_W-1:0]       query_set_i,
    input  logic [WAY_W-1:0]       query_way_i,
    output logic                   query_inflight_o,
    output logic                   query_full_o,
    input  logic                   merge_valid_i,
    input  logic                   fill_valid_i,
    input  logic [SET_W+WAY_W-1:0] fill_id_i,
    input  logic                   release_valid_i,
    input  logic [SET_W+WAY_W-1:0] release_id_i,
    output logic [ICW-1:0]         inflight_cnt_o,
    output logic                   err_o
);

    localparam int ID_W = SET_W + WAY_W;
    localparam int N    = 1 << ID_W;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [ICW-1:0]   CAP     = ICW'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        FILLED = 2'd2
    } ent_state_e;

    ent_state_e       state_q [N];
    ent_state_e       state_d [N];
    logic [CNT_W-1:0] wait_q  [N];
    logic [CNT_W-1:0] wait_d  [N];
    logic [ICW-1:0]   cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [ID_W-1:0] alloc_id, query_id;
    logic            alloc_fire;
    logic            merge_ok, fill_ok, release_ok;
    logic            merge_rel_same;
    logic            free_line;

    assign alloc_id = {alloc_set_i, alloc_way_i};
    assign query_id = {query_set_i, query_way_i};

    // All status outputs look only at registered state: a same-cycle
    // alloc, fill or release is never bypassed to the query/ready path.
    assign query_inflight_o = (state_q[query_id] != IDLE);
    assign query_full_o     = (wait_q[query_id] == CNT_MAX);
    assign alloc_ready_o    = (cnt_q < CAP) && (state_q[alloc_id] == IDLE);
    assign inflight_cnt_o   = cnt_q;
    assign err_o            = err_q;

    assign alloc_fire = alloc_valid_i && alloc_ready_o;
    assign merge_ok   = merge_valid_i && query_inflight_o && !query_full_o;
    assign fill_ok    = fill_valid_i && (state_q[fill_id_i] == PEND);
    assign release_ok = release_valid_i && (state_q[release_id_i] == FILLED)
                        && (wait_q[release_id_i] != '0);

    // A merge and a release on the same line cancel, so the line cannot free.
    assign merge_rel_same = merge_ok && (query_id == release_id_i);
    assign free_line      = release_ok && !merge_rel_same
                            && (wait_q[release_id_i] == CNT_ONE);

    always_comb begin
        // NOTE: every variable gets a default before any conditional update,
        // so no path leaves a value unassigned and no latch is inferred.
        cnt_d = cnt_q;
        err_d = (merge_valid_i && !merge_ok)
              | (fill_valid_i && !fill_ok)
              | (release_valid_i && !release_ok);

        case ({alloc_fire, free_line})
            2'b10:   cnt_d = cnt_q + ICW'(1);
            2'b01:   cnt_d = cnt_q - ICW'(1);
            default: cnt_d = cnt_q;
        endcase

        for (int i = 0; i < N; i++) begin
            state_d[i] = state_q[i];
            wait_d[i]  = wait_q[i];

            // An allocated entry was IDLE, so no legal merge, fill or
            // release can target it in the same cycle.
            if (alloc_fire && (alloc_id == ID_W'(i))) begin
                state_d[i] = PEND;
                wait_d[i]  = CNT_ONE;
            end else begin
                if (fill_ok && (fill_id_i == ID_W'(i)))
                    state_d[i] = FILLED;

                if ((merge_ok && (query_id == ID_W'(i)))
                    && !(release_ok && (release_id_i == ID_W'(i)))) begin
                    wait_d[i] = wait_q[i] + CNT_ONE;
                end else if ((release_ok && (release_id_i == ID_W'(i)))
                             && !(merge_ok && (query_id == ID_W'(i)))) begin
                    wait_d[i] = wait_q[i] - CNT_ONE;
                    if (wait_q[i] == CNT_ONE)
                        state_d[i] = IDLE;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the entry table is flops rather than a RAM macro, and
            // every entry must read IDLE after reset, so it is reset in full.
            for (int i = 0; i < N; i++) begin
                state_q[i] <= IDLE;
                wait_q[i]  <= '0;
            end
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_bank_isu_linefill_tracker.sv
// -----------------------------------------------------------------------------
// tb_bank_isu_linefill_tracker
//
// Table-driven bench: each record holds one cycle of inputs plus the outputs
// expected just after that cycle's clock edge (query/ready evaluated with the
// same inputs still applied). Hand-written sequences cover reset behaviour.
// The DUT is built with MAX_INFLIGHT = 4 so the capacity cap is reachable.
// -----------------------------------------------------------------------------
module tb_bank_isu_linefill_tracker;

    localparam int SET_W = 3;
    localparam int WAY_W = 3;
    localparam int CNT_W = 3;
    localparam int MAXI  = 4;
    localparam int ICW   = 3;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             alloc_valid_i;
    logic [2:0]       alloc_set_i, alloc_way_i;
    logic             alloc_ready_o;
    logic [2:0]       query_set_i, query_way_i;
    logic             query_inflight_o, query_full_o;
    logic             merge_valid_i;
    logic             fill_valid_i;
    logic [5:0]       fill_id_i;
    logic             release_valid_i;
    logic [5:0]       release_id_i;
    logic [ICW-1:0]   inflight_cnt_o;
    logic             err_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    bank_isu_linefill_tracker #(
        .SET_W(SET_W), .WAY_W(WAY_W), .CNT_W(CNT_W), .MAX_INFLIGHT(MAXI)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .alloc_valid_i   (alloc_valid_i),
        .alloc_set_i     (alloc_set_i),
        .alloc_way_i     (alloc_way_i),
        .alloc_ready_o   (alloc_ready_o),
        .query_set_i     (query_set_i),
        .query_way_i     (query_way_i),
        .query_inflight_o(query_inflight_o),
        .query_full_o    (query_full_o),
        .merge_valid_i   (merge_valid_i),
        .fill_valid_i    (fill_valid_i),
        .fill_id_i       (fill_id_i),
        .release_valid_i (release_valid_i),
        .release_id_i    (release_id_i),
        .inflight_cnt_o  (inflight_cnt_o),
        .err_o           (err_o)
    );

    typedef struct {
        string      name;
        logic       av;
        logic [2:0] as, aw, qs, qw;
        logic       mv, fv;
        logic [5:0] fid;
        logic       rv;
        logic [5:0] rid;
        logic       e_inf, e_full, e_rdy;
        logic [2:0] e_cnt;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string n, input int av, input int as,
                                input int aw, input int qs, input int qw,
                                input int mv, input int fv, input int fid,
                                input int rv, input int rid, input int inf,
                                input int full, input int rdy, input int cnt,
                                input int err);
        vec_t v;
        v.name = n;
        v.av = 1'(av);   v.as = 3'(as);  v.aw = 3'(aw);
        v.qs = 3'(qs);   v.qw = 3'(qw);  v.mv = 1'(mv);
        v.fv = 1'(fv);   v.fid = 6'(fid);
        v.rv = 1'(rv);   v.rid = 6'(rid);
        v.e_inf = 1'(inf); v.e_full = 1'(full); v.e_rdy = 1'(rdy);
        v.e_cnt = 3'(cnt); v.e_err = 1'(err);
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        alloc_valid_i = 1'b0; alloc_set_i = '0; alloc_way_i = '0;
        query_set_i = '0; query_way_i = '0; merge_valid_i = 1'b0;
        fill_valid_i = 1'b0; fill_id_i = '0;
        release_valid_i = 1'b0; release_id_i = '0;
    endtask

    initial begin
        // Single linefill for (2,5), id 0x15.
        add("alloc25",     1,2,5,2,5, 0,0,0,    0,0,     1,0,0,1,0);
        add("fill15",      0,2,5,2,5, 0,1,'h15, 0,0,     1,0,0,1,0);
        add("rel15",       0,2,5,2,5, 0,0,0,    1,'h15,  0,0,1,0,0);
        // Merge up to saturation on (1,1), id 9.
        add("alloc11",     1,1,1,1,1, 0,0,0,    0,0,     1,0,0,1,0);
        for (int k = 1; k <= 6; k++)
            add($sformatf("merge%0d", k), 0,1,1,1,1, 1,0,0, 0,0,
                1, (k == 6) ? 1 : 0, 0,1,0);
        add("merge_sat",   0,1,1,1,1, 1,0,0,    0,0,     1,1,0,1,1);
        add("fill09",      0,1,1,1,1, 0,1,9,    0,0,     1,1,0,1,0);
        for (int k = 1; k <= 7; k++)
            add($sformatf("rel09_%0d", k), 0,1,1,1,1, 0,0,0, 1,9,
                (k < 7) ? 1 : 0, 0, (k == 7) ? 1 : 0, (k < 7) ? 1 : 0, 0);
        // Capacity cap: lines (0,0)..(0,3) in flight, (0,4) blocked.
        for (int k = 0; k < 4; k++)
            add($sformatf("alloc_cap%0d", k), 1,0,k,0,k, 0,0,0, 0,0,
                1,0,0,k+1,0);
        add("cap_block",   1,0,4,0,4, 0,0,0,    0,0,     0,0,0,4,0);
        for (int k = 0; k < 4; k++)
            add($sformatf("fill_cap%0d", k), 0,0,4,0,k, 0,1,k, 0,0,
                1,0,0,4,0);
        add("cap_free",    0,0,4,0,3, 0,0,0,    1,3,     0,0,1,3,0);
        // Protocol errors.
        add("fill_idle",   0,7,7,7,7, 0,1,'h3f, 0,0,     0,0,1,3,1);
        add("alloc66",     1,6,6,6,6, 0,0,0,    0,0,     1,0,0,4,0);
        add("rel_pend",    0,6,6,6,6, 0,0,0,    1,'h36,  1,0,0,4,1);
        add("rel_idle",    0,7,7,7,7, 0,0,0,    1,'h3f,  0,0,0,4,1);
        // Simultaneous events.
        add("merge_rel",   0,0,0,0,0, 1,0,0,    1,0,     1,0,0,4,0);
        add("fill66",      0,6,6,6,6, 0,1,'h36, 0,0,     1,0,0,4,0);
        add("rel66",       0,6,6,6,6, 0,0,0,    1,'h36,  0,0,1,3,0);
        add("alloc_free",  1,7,7,7,7, 0,0,0,    1,1,     1,0,0,3,0);
        add("merge_alloc", 1,5,5,5,5, 1,0,0,    0,0,     1,0,0,4,1);
        add("fill_merge",  0,5,5,5,5, 1,1,'h2d, 0,0,     1,0,0,4,0);
        add("fill_relpnd", 0,7,7,7,7, 0,1,'h3f, 1,'h3f,  1,0,0,4,1);
        add("rel00",       0,0,0,0,0, 0,0,0,    1,0,     0,0,1,3,0);

        // Reset and post-reset state.
        idle_inputs();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("rst_inflight", 32'(query_inflight_o), 32'd0);
        check("rst_full",     32'(query_full_o),     32'd0);
        check("rst_ready",    32'(alloc_ready_o),    32'd1);
        check("rst_cnt",      32'(inflight_cnt_o),   32'd0);
        check("rst_err",      32'(err_o),            32'd0);

        foreach (vecs[i]) begin
            @(negedge clk_i);
            alloc_valid_i   = vecs[i].av;
            alloc_set_i     = vecs[i].as;
            alloc_way_i     = vecs[i].aw;
            query_set_i     = vecs[i].qs;
            query_way_i     = vecs[i].qw;
            merge_valid_i   = vecs[i].mv;
            fill_valid_i    = vecs[i].fv;
            fill_id_i       = vecs[i].fid;
            release_valid_i = vecs[i].rv;
            release_id_i    = vecs[i].rid;
            @(posedge clk_i);
            #1;
            check({vecs[i].name, ".inflight"}, 32'(query_inflight_o), 32'(vecs[i].e_inf));
            check({vecs[i].name, ".full"},     32'(query_full_o),     32'(vecs[i].e_full));
            check({vecs[i].name, ".ready"},    32'(alloc_ready_o),    32'(vecs[i].e_rdy));
            check({vecs[i].name, ".cnt"},      32'(inflight_cnt_o),   32'(vecs[i].e_cnt));
            check({vecs[i].name, ".err"},      32'(err_o),            32'(vecs[i].e_err));
        end

        // Reset mid-flight: (0,2), (5,5), (7,7) are FILLED. Inputs in the
        // reset cycle carry an alloc and an illegal release; both are ignored.
        @(negedge clk_i);
        rst_i = 1'b1;
        alloc_valid_i = 1'b1; alloc_set_i = 3'd3; alloc_way_i = 3'd3;
        release_valid_i = 1'b1; release_id_i = 6'h3e;
        merge_valid_i = 1'b0; fill_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("midrst_cnt", 32'(inflight_cnt_o), 32'd0);
        check("midrst_err", 32'(err_o),          32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        idle_inputs();
        alloc_set_i = 3'd5; alloc_way_i = 3'd5;
        query_set_i = 3'd0; query_way_i = 3'd2;
        #1;
        check("midrst_q02",   32'(query_inflight_o), 32'd0);
        check("midrst_ready", 32'(alloc_ready_o),    32'd1);
        query_set_i = 3'd5; query_way_i = 3'd5;
        #1;
        check("midrst_q55", 32'(query_inflight_o), 32'd0);
        query_set_i = 3'd7; query_way_i = 3'd7;
        #1;
        check("midrst_q77", 32'(query_inflight_o), 32'd0);
        check("midrst_q77_full", 32'(query_full_o), 32'd0);
        @(posedge clk_i);
        #1;
        check("postrst_err", 32'(err_o),          32'd0);
        check("postrst_cnt", 32'(inflight_cnt_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
